// File: rtl/mcyc_control.sv
// Multi-cycle datapath sequencer: steps fetch/decode/execute/writeback phases
// and issues the datapath write enables, mux selects and memory strobes.
//   state   | meaning
//   0 FETCH | read instruction, PC+4     7 RWB    | R-type register writeback
//   1 DECODE| read regs, branch target   8 BRANCH | compare, conditional PC load
//   2 MEMADR| effective address          9 JUMP   | PC <- jump address
//   3 MEMRD | load data read            10 IEXEC  | immediate ALU op
//   4 MEMWB | load writeback            11 IWB    | immediate writeback
//   5 MEMWR | store write               12 JR     | PC <- regA
//   6 EXEC  | R-type ALU op             15 HALT   | stopped until reset
module mcyc_control #(
  parameter int ICNT_W = 32
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic [5:0]        op,
  input  logic [5:0]        func,
  input  logic              zero,
  input  logic              mem_ready,
  output logic              ir_we,
  output logic              mdr_we,
  output logic              rega_we,
  output logic              regb_we,
  output logic              aluout_we,
  output logic              pc_we,
  output logic              reg_we,
  output logic              mem_to_reg,
  output logic              reg_dst,
  output logic              alu_src_a,
  output logic              iord,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [2:0]        alu_src_b,
  output logic [2:0]        pc_src,
  output logic [3:0]        alu_op,
  output logic [3:0]        state,
  output logic              halted,
  output logic [ICNT_W-1:0] icount
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,  S_DECODE = 4'd1,  S_MEMADR = 4'd2,  S_MEMRD = 4'd3,
    S_MEMWB  = 4'd4,  S_MEMWR  = 4'd5,  S_EXEC   = 4'd6,  S_RWB   = 4'd7,
    S_BRANCH = 4'd8,  S_JUMP   = 4'd9,  S_IEXEC  = 4'd10, S_IWB   = 4'd11,
    S_JR     = 4'd12, S_HALT   = 4'd15
  } state_t;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;

  state_t              r_state;
  state_t              w_next;
  logic [ICNT_W-1:0]   r_icount;
  logic                w_func_ok;
  logic [3:0]          w_func_op;

  always_comb begin
    w_func_ok = 1'b1;
    w_func_op = ALU_AND;
    case (func)
      6'h20:   w_func_op = ALU_ADD;
      6'h22:   w_func_op = ALU_SUB;
      6'h24:   w_func_op = ALU_AND;
      6'h25:   w_func_op = ALU_OR;
      6'h2A:   w_func_op = ALU_SLT;
      default: w_func_ok = 1'b0;
    endcase
  end

  always_comb begin
    w_next     = r_state;
    ir_we      = 1'b0;
    mdr_we     = 1'b0;
    rega_we    = 1'b0;
    regb_we    = 1'b0;
    aluout_we  = 1'b0;
    pc_we      = 1'b0;
    reg_we     = 1'b0;
    mem_to_reg = 1'b0;
    reg_dst    = 1'b0;
    alu_src_a  = 1'b0;
    iord       = 1'b0;
    mem_rd     = 1'b0;
    mem_wr     = 1'b0;
    alu_src_b  = 3'd0;
    pc_src     = 3'd0;
    alu_op     = ALU_AND;
    halted     = 1'b0;
    case (r_state)
      S_FETCH: begin
        mem_rd    = 1'b1;
        alu_src_b = 3'd4;
        alu_op    = ALU_ADD;
        if (mem_ready) begin
          ir_we  = 1'b1;
          pc_we  = 1'b1;
          w_next = S_DECODE;
        end
      end
      S_DECODE: begin
        rega_we   = 1'b1;
        regb_we   = 1'b1;
        aluout_we = 1'b1;
        alu_src_b = 3'd3;
        alu_op    = ALU_ADD;
        case (op)
          6'h00:               w_next = (func == 6'h08) ? S_JR : S_EXEC;
          6'h23, 6'h2B:        w_next = S_MEMADR;
          6'h04, 6'h05:        w_next = S_BRANCH;
          6'h02:               w_next = S_JUMP;
          6'h08, 6'h0C, 6'h0D: w_next = S_IEXEC;
          default:             w_next = S_HALT;
        endcase
      end
      S_EXEC: begin
        alu_src_a = 1'b1;
        if (w_func_ok) begin
          alu_op    = w_func_op;
          aluout_we = 1'b1;
          w_next    = S_RWB;
        end else begin
          w_next = S_HALT;
        end
      end
      S_RWB: begin
        reg_we  = 1'b1;
        reg_dst = 1'b1;
        w_next  = S_FETCH;
      end
      S_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 3'd2;
        alu_op    = ALU_ADD;
        aluout_we = 1'b1;
        if (op == 6'h23)      w_next = S_MEMRD;
        else if (op == 6'h2B) w_next = S_MEMWR;
        else                  w_next = S_HALT;
      end
      S_MEMRD: begin
        iord   = 1'b1;
        mem_rd = 1'b1;
        if (mem_ready) begin
          mdr_we = 1'b1;
          w_next = S_MEMWB;
        end
      end
      S_MEMWB: begin
        reg_we     = 1'b1;
        mem_to_reg = 1'b1;
        w_next     = S_FETCH;
      end
      S_MEMWR: begin
        iord   = 1'b1;
        mem_wr = 1'b1;
        if (mem_ready) w_next = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a = 1'b1;
        alu_op    = ALU_SUB;
        pc_src    = 3'd1;
        pc_we     = (op == 6'h04) ? zero : ((op == 6'h05) ? !zero : 1'b0);
        w_next    = S_FETCH;
      end
      S_JUMP: begin
        pc_we  = 1'b1;
        pc_src = 3'd2;
        w_next = S_FETCH;
      end
      S_JR: begin
        pc_we  = 1'b1;
        pc_src = 3'd3;
        w_next = S_FETCH;
      end
      S_IEXEC: begin
        alu_src_a = 1'b1;
        aluout_we = 1'b1;
        w_next    = S_IWB;
        case (op)
          6'h08:   begin alu_src_b = 3'd2; alu_op = ALU_ADD; end
          6'h0C:   begin alu_src_b = 3'd5; alu_op = ALU_AND; end
          6'h0D:   begin alu_src_b = 3'd5; alu_op = ALU_OR;  end
          default: begin alu_src_b = 3'd0; alu_op = ALU_AND; end
        endcase
      end
      S_IWB: begin
        reg_we = 1'b1;
        w_next = S_FETCH;
      end
      S_HALT:  halted = 1'b1;
      default: w_next = S_HALT;
    endcase
  end

  // icount advances only when a fetch actually completes
  always_ff @(posedge clk) begin
    if (!nrst) begin
      r_state  <= S_FETCH;
      r_icount <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_FETCH && mem_ready) r_icount <= r_icount + ICNT_W'(1);
    end
  end

  assign state  = r_state;
  assign icount = r_icount;

endmodule

// File: tb/tb_mcyc_control.sv
// Scoreboard bench for mcyc_control: a per-instruction phase model pushes the
// expected cycle-by-cycle response; a negedge monitor pops and compares.
module tb_mcyc_control;
  localparam int W = 6;
  localparam logic [3:0] S_FETCH = 0, S_DECODE = 1, S_MEMADR = 2, S_MEMRD = 3,
    S_MEMWB = 4, S_MEMWR = 5, S_EXEC = 6, S_RWB = 7, S_BRANCH = 8, S_JUMP = 9,
    S_IEXEC = 10, S_IWB = 11, S_JR = 12, S_HALT = 15;
  localparam logic [3:0] A_AND = 4'b0000, A_OR = 4'b0001, A_ADD = 4'b0010,
    A_SUB = 4'b0110, A_SLT = 4'b0111;

  logic clk = 0, nrst = 0, zero = 0, mem_ready = 0;
  logic [5:0] op = 0, func = 0;
  logic ir_we, mdr_we, rega_we, regb_we, aluout_we, pc_we, reg_we;
  logic mem_to_reg, reg_dst, alu_src_a, iord, mem_rd, mem_wr, halted;
  logic [2:0] alu_src_b, pc_src;
  logic [3:0] alu_op, state;
  logic [W-1:0] icount;

  mcyc_control #(.ICNT_W(W)) dut (
    .clk(clk), .nrst(nrst), .op(op), .func(func), .zero(zero), .mem_ready(mem_ready),
    .ir_we(ir_we), .mdr_we(mdr_we), .rega_we(rega_we), .regb_we(regb_we),
    .aluout_we(aluout_we), .pc_we(pc_we), .reg_we(reg_we), .mem_to_reg(mem_to_reg),
    .reg_dst(reg_dst), .alu_src_a(alu_src_a), .iord(iord), .mem_rd(mem_rd),
    .mem_wr(mem_wr), .alu_src_b(alu_src_b), .pc_src(pc_src), .alu_op(alu_op),
    .state(state), .halted(halted), .icount(icount)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic ir_we, mdr_we, rega_we, regb_we, aluout_we, pc_we, reg_we;
    logic mem_to_reg, reg_dst, alu_src_a, iord, mem_rd, mem_wr, halted;
    logic [2:0] alu_src_b, pc_src;
    logic [3:0] alu_op;
  } ctl_t;

  typedef struct packed {
    logic chk;
    logic [3:0] st;
    ctl_t c;
    logic [W-1:0] ic;
  } exp_t;

  ctl_t act;
  assign act = {ir_we, mdr_we, rega_we, regb_we, aluout_we, pc_we, reg_we,
                mem_to_reg, reg_dst, alu_src_a, iord, mem_rd, mem_wr, halted,
                alu_src_b, pc_src, alu_op};

  exp_t q[$];
  int n_chk = 0, n_fail = 0;
  logic [W-1:0] m_ic = '0;
  logic [5:0] cur_op = 0, cur_func = 0;
  logic cur_zero = 0, m_halted = 0;
  int halt_len = 3;

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic ctl_t fetch_ctl();
    ctl_t c = '0;
    c.mem_rd = 1; c.alu_src_b = 3'd4; c.alu_op = A_ADD;
    return c;
  endfunction

  task automatic cyc(input logic rn, input logic mr, input logic [3:0] st,
                     input ctl_t c, input logic chk);
    exp_t e;
    @(posedge clk); #1;
    nrst = rn; mem_ready = mr; op = cur_op; func = cur_func; zero = cur_zero;
    e.chk = chk; e.st = st; e.c = c; e.ic = m_ic;
    q.push_back(e);
  endtask

  task automatic do_rst(input logic mr, input logic [3:0] st, input ctl_t c, input logic chk);
    cyc(0, mr, st, c, chk);
    m_ic = '0;
    m_halted = 0;
  endtask

  task automatic halt_run();
    ctl_t c = '0;
    c.halted = 1;
    m_halted = 1;
    repeat (halt_len) cyc(1, rb(), S_HALT, c, 1);
  endtask

  // One instruction as a phase script; ab>=0 pulls reset in that store stall cycle.
  task automatic issue(input logic [5:0] o, input logic [5:0] f, input logic z,
                       input int fst, input int mst, input int ab);
    ctl_t c;
    logic bad;
    cur_op = o; cur_func = f; cur_zero = z;
    c = fetch_ctl();
    repeat (fst) cyc(1, 0, S_FETCH, c, 1);
    c.ir_we = 1; c.pc_we = 1;
    cyc(1, 1, S_FETCH, c, 1);
    m_ic++;
    c = '0; c.rega_we = 1; c.regb_we = 1; c.aluout_we = 1; c.alu_src_b = 3'd3; c.alu_op = A_ADD;
    cyc(1, rb(), S_DECODE, c, 1);
    c = '0;
    if (o == 6'h00 && f == 6'h08) begin
      c.pc_we = 1; c.pc_src = 3'd3;
      cyc(1, rb(), S_JR, c, 1);
    end else if (o == 6'h00) begin
      bad = 0;
      c.alu_src_a = 1;
      case (f)
        6'h20: c.alu_op = A_ADD;
        6'h22: c.alu_op = A_SUB;
        6'h24: c.alu_op = A_AND;
        6'h25: c.alu_op = A_OR;
        6'h2A: c.alu_op = A_SLT;
        default: bad = 1;
      endcase
      c.aluout_we = !bad;
      cyc(1, rb(), S_EXEC, c, 1);
      if (bad) halt_run();
      else begin
        c = '0; c.reg_we = 1; c.reg_dst = 1;
        cyc(1, rb(), S_RWB, c, 1);
      end
    end else if (o == 6'h23 || o == 6'h2B) begin
      c.alu_src_a = 1; c.alu_src_b = 3'd2; c.alu_op = A_ADD; c.aluout_we = 1;
      cyc(1, rb(), S_MEMADR, c, 1);
      c = '0; c.iord = 1;
      if (o == 6'h23) begin
        c.mem_rd = 1;
        repeat (mst) cyc(1, 0, S_MEMRD, c, 1);
        c.mdr_we = 1;
        cyc(1, 1, S_MEMRD, c, 1);
        c = '0; c.reg_we = 1; c.mem_to_reg = 1;
        cyc(1, rb(), S_MEMWB, c, 1);
      end else begin
        c.mem_wr = 1;
        for (int i = 0; i < mst; i++) begin
          if (i == ab) begin
            do_rst(0, S_MEMWR, c, 1);
            return;
          end
          cyc(1, 0, S_MEMWR, c, 1);
        end
        cyc(1, 1, S_MEMWR, c, 1);
      end
    end else if (o == 6'h04 || o == 6'h05) begin
      c.alu_src_a = 1; c.alu_op = A_SUB; c.pc_src = 3'd1;
      c.pc_we = (o == 6'h04) ? z : !z;
      cyc(1, rb(), S_BRANCH, c, 1);
    end else if (o == 6'h02) begin
      c.pc_we = 1; c.pc_src = 3'd2;
      cyc(1, rb(), S_JUMP, c, 1);
    end else if (o == 6'h08 || o == 6'h0C || o == 6'h0D) begin
      c.alu_src_a = 1; c.aluout_we = 1;
      c.alu_src_b = (o == 6'h08) ? 3'd2 : 3'd5;
      c.alu_op = (o == 6'h08) ? A_ADD : ((o == 6'h0C) ? A_AND : A_OR);
      cyc(1, rb(), S_IEXEC, c, 1);
      c = '0; c.reg_we = 1;
      cyc(1, rb(), S_IWB, c, 1);
    end else begin
      halt_run();
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      if (e.chk) begin
        n_chk += 5;
        if (state !== e.st) begin
          n_fail++; $display("FAIL state t=%0t got %0d expected %0d", $time, state, e.st);
        end
        if (act !== e.c) begin
          n_fail++; $display("FAIL ctl t=%0t st=%0d got %h expected %h", $time, e.st, act, e.c);
        end
        if (icount !== e.ic) begin
          n_fail++; $display("FAIL icount t=%0t got %0d expected %0d", $time, icount, e.ic);
        end
        if (mem_rd && mem_wr) begin
          n_fail++; $display("FAIL rd_wr_excl t=%0t got both strobes expected at most one", $time);
        end
        if (32'(pc_we) + 32'(reg_we) + 32'(mdr_we) > 1) begin
          n_fail++; $display("FAIL we_excl t=%0t got pc=%0b reg=%0b mdr=%0b expected at most one",
                             $time, pc_we, reg_we, mdr_we);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [5:0] ops[11] = '{6'h00, 6'h00, 6'h00, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h02, 6'h08, 6'h0C, 6'h0D};
    logic [5:0] fns[6]  = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h08};
    logic [5:0] bad_ops[5] = '{6'h01, 6'h03, 6'h10, 6'h2A, 6'h3F};
    logic [5:0] o, f;
    do_rst(0, S_FETCH, '0, 0);
    issue(6'h00, 6'h20, 0, 0, 0, -1);
    issue(6'h23, 6'h00, 0, 0, 3, -1);
    issue(6'h04, 6'h00, 1, 0, 0, -1);
    issue(6'h05, 6'h00, 1, 0, 0, -1);
    issue(6'h04, 6'h00, 0, 1, 0, -1);
    issue(6'h05, 6'h00, 0, 0, 0, -1);
    issue(6'h2B, 6'h00, 0, 2, 2, -1);
    issue(6'h02, 6'h00, 0, 0, 0, -1);
    issue(6'h00, 6'h08, 0, 0, 0, -1);
    issue(6'h08, 6'h00, 0, 0, 0, -1);
    issue(6'h0C, 6'h00, 0, 0, 0, -1);
    issue(6'h0D, 6'h00, 0, 0, 0, -1);
    issue(6'h00, 6'h22, 0, 0, 0, -1);
    issue(6'h00, 6'h24, 0, 0, 0, -1);
    issue(6'h00, 6'h25, 0, 0, 0, -1);
    issue(6'h00, 6'h2A, 0, 0, 0, -1);
    do_rst(1, S_FETCH, fetch_ctl(), 0);
    issue(6'h2B, 6'h00, 0, 0, 3, 1);
    issue(6'h00, 6'h20, 0, 0, 0, -1);
    halt_len = 12;
    issue(6'h3F, 6'h00, 0, 0, 0, -1);
    begin
      ctl_t hc = '0;
      hc.halted = 1;
      do_rst(1, S_HALT, hc, 1);
    end
    cyc(1, 0, S_FETCH, fetch_ctl(), 1);
    do_rst(0, S_FETCH, fetch_ctl(), 1);
    halt_len = 3;
    issue(6'h00, 6'h21, 0, 0, 0, -1);
    do_rst(1, S_HALT, '{halted: 1'b1, default: '0}, 1);
    repeat (70) issue(6'h02, 6'h00, 0, 0, 0, -1);
    for (int n = 0; n < 300; n++) begin
      o = ops[$urandom_range(0, 10)];
      f = fns[$urandom_range(0, 5)];
      if ($urandom_range(0, 29) == 0) o = bad_ops[$urandom_range(0, 4)];
      if (o == 6'h00 && $urandom_range(0, 24) == 0) f = 6'h21;
      halt_len = $urandom_range(2, 5);
      issue(o, f, rb(), $urandom_range(0, 2), $urandom_range(0, 3), -1);
      if (m_halted) do_rst(rb(), S_HALT, '{halted: 1'b1, default: '0}, 1);
      else if ($urandom_range(0, 19) == 0) begin
        cyc(1, 0, S_FETCH, fetch_ctl(), 1);
        do_rst(0, S_FETCH, fetch_ctl(), 1);
      end
    end
    repeat (2) @(negedge clk);
    n_chk++;
    if (q.size() != 0) begin
      n_fail++; $display("FAIL drain got %0d pending expected 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
